md_seq: RTL and testbench

MD_SEQ -- requirements
Module: md_seq

---
 rtl/md_seq_if.sv | 34 +++
 rtl/md_seq.sv | 134 +++++++++++++
 tb/tb_md_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_seq_if.sv
`default_nettype none
// == md_seq_if | EX-stage <-> multiply/divide sequencer bus | rev 1.0 ==
interface md_seq_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic        flush_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        mac_phase_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [63:0] result_o;
  logic        err_o;

  modport slave (
    input  start_i, op_i, flush_i, opdata1_i, opdata2_i, div_ready_i, div_result_i,
    output div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           mac_phase_o, stallreq_o, whilo_o, result_o, err_o
  );

  modport master (
    output start_i, op_i, flush_i, opdata1_i, opdata2_i, div_ready_i, div_result_i,
    input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           mac_phase_o, stallreq_o, whilo_o, result_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/md_seq.sv
`default_nettype none
// == md_seq | multi-cycle MAC / divide sequencer with divider handshake and timeout | rev 1.0 ==
module md_seq (
  input  wire logic clk,
  input  wire logic rst,
  md_seq_if.slave   bus
);

  localparam logic [2:0] OP_MADD  = 3'b001;
  localparam logic [2:0] OP_MADDU = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MSUBU = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b110;
  localparam logic [5:0] TIMEOUT  = 6'd40;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAC_ACC  = 2'd1,
    DIV_WAIT = 2'd2,
    DIV_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  wait_cnt;
  logic        div_start;
  logic        annul_pulse;
  logic        div_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        mac_phase;
  logic        whilo_q;
  logic [63:0] result;
  logic        err;

  logic is_mac;
  logic is_div;

  assign is_mac = (bus.op_i == OP_MADD) || (bus.op_i == OP_MADDU) ||
                  (bus.op_i == OP_MSUB) || (bus.op_i == OP_MSUBU);
  assign is_div = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 6'd0;
      div_start   <= 1'b0;
      annul_pulse <= 1'b0;
      div_signed  <= 1'b0;
      opa         <= 32'd0;
      opb         <= 32'd0;
      mac_phase   <= 1'b0;
      whilo_q     <= 1'b0;
      result      <= 64'd0;
      err         <= 1'b0;
    end else begin
      annul_pulse <= 1'b0;
      err         <= 1'b0;
      if (bus.flush_i) begin
        state     <= IDLE;
        div_start <= 1'b0;
        mac_phase <= 1'b0;
        whilo_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i && is_mac) begin
              state     <= MAC_ACC;
              mac_phase <= 1'b1;
              whilo_q   <= 1'b1;
            end else if (bus.start_i && is_div) begin
              if (bus.opdata2_i != 32'd0) begin
                opa        <= bus.opdata1_i;
                opb        <= bus.opdata2_i;
                div_signed <= (bus.op_i == OP_DIV);
                div_start  <= 1'b1;
                wait_cnt   <= 6'd0;
                state      <= DIV_WAIT;
              end else begin
                // divide by zero never reaches the divider
                result  <= 64'd0;
                whilo_q <= 1'b1;
                state   <= DIV_DONE;
              end
            end
          end
          MAC_ACC: begin
            mac_phase <= 1'b0;
            whilo_q   <= 1'b0;
            state     <= IDLE;
          end
          DIV_WAIT: begin
            if (bus.div_ready_i) begin
              result    <= bus.div_result_i;
              div_start <= 1'b0;
              whilo_q   <= 1'b1;
              state     <= DIV_DONE;
            end else if (wait_cnt == TIMEOUT) begin
              result      <= 64'd0;
              div_start   <= 1'b0;
              annul_pulse <= 1'b1;
              err         <= 1'b1;
              whilo_q     <= 1'b1;
              state       <= DIV_DONE;
            end else begin
              wait_cnt <= wait_cnt + 6'd1;
            end
          end
          DIV_DONE: begin
            whilo_q <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // flush must silence the stall and the HI/LO write in the same cycle it arrives
  assign bus.stallreq_o    = !rst && !bus.flush_i &&
                             (((state == IDLE) && bus.start_i && (is_mac || is_div)) ||
                              (state == DIV_WAIT));
  assign bus.whilo_o       = whilo_q && !bus.flush_i;
  assign bus.div_annul_o   = annul_pulse || ((state == DIV_WAIT) && bus.flush_i);
  assign bus.div_start_o   = div_start;
  assign bus.div_signed_o  = div_signed;
  assign bus.div_opdata1_o = opa;
  assign bus.div_opdata2_o = opb;
  assign bus.mac_phase_o   = mac_phase;
  assign bus.result_o      = result;
  assign bus.err_o         = err;

endmodule
`default_nettype wire

// File: tb/tb_md_seq.sv
`default_nettype none
// == tb_md_seq | randomized self-checking bench for md_seq with a transaction-level model | rev 1.0 ==
module tb_md_seq;

  logic clk;
  logic rst;
  md_seq_if bus ();

  md_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ideal divider: {remainder, quotient}, truncating toward zero
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // One whole transaction from an IDLE cycle; lat = wait cycle with div_ready,
  // flush_at: -1 none, -2 flush at issue, >=0 wait cycle (or MAC_ACC for MAC ops).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int flush_at);
    logic mac;
    logic dv;
    logic sgn;
    logic tmo;
    logic [63:0] exp_res;
    mac = (op >= 3'd1) && (op <= 3'd4);
    dv  = (op == 3'd5) || (op == 3'd6);
    sgn = (op == 3'd5);
    exp_res = div_ref(a, b, sgn);

    bus.start_i = 1'b1; bus.op_i = op; bus.opdata1_i = a; bus.opdata2_i = b;
    bus.flush_i = (flush_at == -2); bus.div_ready_i = 1'b0;
    bus.div_result_i = {$urandom, $urandom};
    #1;
    chk("issue_stall", bus.stallreq_o, (mac || dv) && (flush_at != -2));
    chk("issue_phase", bus.mac_phase_o, 0);
    chk("issue_whilo", bus.whilo_o, 0);
    chk("issue_dstart", bus.div_start_o, 0);
    chk("issue_annul", bus.div_annul_o, 0);
    chk("issue_err", bus.err_o, 0);
    step();

    if (!(mac || dv) || flush_at == -2) begin
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      #1;
      chk("noacc_stall", bus.stallreq_o, 0);
      chk("noacc_phase", bus.mac_phase_o, 0);
      chk("noacc_whilo", bus.whilo_o, 0);
      chk("noacc_dstart", bus.div_start_o, 0);
      return;
    end

    if (mac) begin
      bus.op_i = 3'($urandom_range(1, 6));
      bus.flush_i = (flush_at >= 0);
      #1;
      chk("mac_phase", bus.mac_phase_o, 1);
      chk("mac_whilo", bus.whilo_o, (flush_at >= 0) ? 0 : 1);
      chk("mac_stall", bus.stallreq_o, 0);
      step();
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      #1;
      chk("mac_end_phase", bus.mac_phase_o, 0);
      chk("mac_end_whilo", bus.whilo_o, 0);
      chk("mac_end_stall", bus.stallreq_o, 0);
      return;
    end

    if (b == 32'd0) begin
      bus.op_i = 3'($urandom_range(0, 7));
      #1;
      chk("dz_whilo", bus.whilo_o, 1);
      chk("dz_result", bus.result_o, 0);
      chk("dz_stall", bus.stallreq_o, 0);
      chk("dz_dstart", bus.div_start_o, 0);
      chk("dz_err", bus.err_o, 0);
      step();
      bus.start_i = 1'b0;
      #1;
      chk("dz_end_whilo", bus.whilo_o, 0);
      return;
    end

    for (int k = 0; k <= 40; k++) begin
      bus.start_i = 1'b1;
      bus.op_i = 3'($urandom_range(0, 7));
      bus.opdata1_i = $urandom; bus.opdata2_i = $urandom;
      bus.flush_i = (k == flush_at);
      bus.div_ready_i = (k == lat);
      bus.div_result_i = (k == lat) ?
          div_ref(bus.div_opdata1_o, bus.div_opdata2_o, bus.div_signed_o) : {$urandom, $urandom};
      #1;
      chk("wait_dstart", bus.div_start_o, 1);
      chk("wait_opa", bus.div_opdata1_o, a);
      chk("wait_opb", bus.div_opdata2_o, b);
      chk("wait_signed", bus.div_signed_o, sgn);
      if (k == flush_at) begin
        chk("flush_stall", bus.stallreq_o, 0);
        chk("flush_annul", bus.div_annul_o, 1);
        chk("flush_whilo", bus.whilo_o, 0);
        step();
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.div_ready_i = 1'b0;
        #1;
        chk("postflush_dstart", bus.div_start_o, 0);
        chk("postflush_stall", bus.stallreq_o, 0);
        chk("postflush_whilo", bus.whilo_o, 0);
        chk("postflush_annul", bus.div_annul_o, 0);
        return;
      end
      chk("wait_stall", bus.stallreq_o, 1);
      chk("wait_annul", bus.div_annul_o, 0);
      chk("wait_whilo", bus.whilo_o, 0);
      if (k == lat || k == 40) begin
        tmo = (k != lat);
        step();
        bus.op_i = 3'($urandom_range(0, 7));
        bus.div_ready_i = 1'b0;
        #1;
        chk("done_whilo", bus.whilo_o, 1);
        chk("done_result", bus.result_o, tmo ? 64'd0 : exp_res);
        chk("done_err", bus.err_o, tmo);
        chk("done_annul", bus.div_annul_o, tmo);
        chk("done_dstart", bus.div_start_o, 0);
        chk("done_stall", bus.stallreq_o, 0);
        step();
        bus.start_i = 1'b0;
        #1;
        chk("after_whilo", bus.whilo_o, 0);
        chk("after_err", bus.err_o, 0);
        chk("after_annul", bus.div_annul_o, 0);
        return;
      end
      step();
    end
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  int          r_lat;
  int          r_fl;
  int          r_sel;

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b1; bus.op_i = 3'b001; bus.flush_i = 1'b0;
    bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0;
    bus.div_ready_i = 1'b0; bus.div_result_i = 64'd0;
    step();
    step();
    chk("rst_stall", bus.stallreq_o, 0);
    chk("rst_dstart", bus.div_start_o, 0);
    chk("rst_annul", bus.div_annul_o, 0);
    chk("rst_signed", bus.div_signed_o, 0);
    chk("rst_opa", bus.div_opdata1_o, 0);
    chk("rst_opb", bus.div_opdata2_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_phase", bus.mac_phase_o, 0);
    chk("rst_whilo", bus.whilo_o, 0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    step();

    do_op(3'b001, 32'd3, 32'd4, 0, -1);
    do_op(3'b101, 32'd100, 32'd7, 34, -1);
    chk("div100_7_hold", bus.result_o, {32'd2, 32'd14});
    do_op(3'b110, 32'd55, 32'd0, 0, -1);
    do_op(3'b101, 32'hFFFF_FF9C, 32'd7, 3, -1);
    do_op(3'b101, 32'd1000, 32'd9, 20, 5);
    do_op(3'b110, 32'd1000, 32'd9, 99, -1);
    do_op(3'b110, 32'hDEAD_BEEF, 32'd13, 40, -1);
    do_op(3'b110, 32'hDEAD_BEEF, 32'd13, 41, -1);
    do_op(3'b011, 32'd1, 32'd2, 0, 0);
    do_op(3'b010, 32'd1, 32'd2, 0, -2);
    do_op(3'b101, 32'd9, 32'd3, 6, 6);
    do_op(3'b000, 32'd1, 32'd1, 0, -1);
    do_op(3'b111, 32'd1, 32'd1, 0, -1);

    // reset while in MAC_ACC
    bus.start_i = 1'b1; bus.op_i = 3'b001;
    step();
    chk("premid_phase", bus.mac_phase_o, 1);
    rst = 1'b1;
    #1;
    chk("midmac_phase", bus.mac_phase_o, 0);
    chk("midmac_whilo", bus.whilo_o, 0);
    chk("midmac_stall", bus.stallreq_o, 0);
    chk("midmac_result", bus.result_o, 0);
    step();
    rst = 1'b0; bus.start_i = 1'b0;
    step();
    do_op(3'b001, 32'd5, 32'd6, 0, -1);

    // reset while the divider is running
    bus.start_i = 1'b1; bus.op_i = 3'b101; bus.opdata1_i = 32'd77; bus.opdata2_i = 32'd5;
    step();
    step();
    chk("middiv_dstart_pre", bus.div_start_o, 1);
    rst = 1'b1;
    #1;
    chk("middiv_dstart", bus.div_start_o, 0);
    chk("middiv_annul", bus.div_annul_o, 0);
    chk("middiv_opa", bus.div_opdata1_o, 0);
    step();
    rst = 1'b0; bus.start_i = 1'b0;
    step();

    for (int i = 0; i < 60; i++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      r_b   = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd7;
      r_lat = $urandom_range(0, 45);
      r_sel = $urandom_range(0, 9);
      r_fl  = (r_sel == 0) ? -2 : (r_sel <= 2) ? int'($urandom_range(0, 40)) : -1;
      do_op(r_op, r_a, r_b, r_lat, r_fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
